// File: rtl/trace_scheduler.sv
`default_nettype none
// ============================================================================
// trace_scheduler : replays a timestamped trace, issuing each request once
//                   the simulated cycle counter reaches its scheduled time.
// Revision        : 1.0
// ============================================================================

package global_defs;
    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_READ  = 2'd1,
        OP_WRITE = 2'd2,
        OP_RSVD  = 2'd3
    } parsed_op_t;
endpackage

module trace_scheduler
    import global_defs::*;
#(
    parameter int ADDRESS_WIDTH = 33,
    parameter int TIME_WIDTH    = 32,
    parameter int DEPTH         = 8,
    parameter int SKIP_IDLE     = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [TIME_WIDTH-1:0]      in_time,
    input  parsed_op_t                 in_op,
    input  logic [ADDRESS_WIDTH-1:0]   in_address,
    output logic                       out_valid,
    input  logic                       out_ready,
    output parsed_op_t                 out_op,
    output logic [ADDRESS_WIDTH-1:0]   out_address,
    output logic [TIME_WIDTH-1:0]      out_time,
    output logic [TIME_WIDTH-1:0]      cycle_count,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       order_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [TIME_WIDTH-1:0]    time_mem [DEPTH];
    parsed_op_t               op_mem   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];

    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [TIME_WIDTH-1:0] cycle_q, cycle_d;
    logic [TIME_WIDTH-1:0] last_time_q, last_time_d;
    logic                  order_err_q, order_err_d;
    logic                  started_q;

    logic                  empty, full, push, pop;
    logic                  head_due, head_nop;
    logic [TIME_WIDTH-1:0] head_time;
    logic [TIME_WIDTH:0]   cycle_plus1;

    always_comb begin
        empty       = (count_q == '0);
        full        = (count_q == FULL_CNT);
        head_time   = time_mem[rd_ptr_q];
        head_nop    = (op_mem[rd_ptr_q] == OP_NOP);
        head_due    = !empty && (head_time <= cycle_q);
        in_ready    = started_q && !full;
        push        = in_valid && in_ready;
        out_valid   = head_due && !head_nop;
        // A due NOP retires on its own; real requests wait for the handshake.
        pop         = head_due && (head_nop || out_ready);
        cycle_plus1 = {1'b0, cycle_q} + {{TIME_WIDTH{1'b0}}, 1'b1};

        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if ((SKIP_IDLE != 0) && !empty && !push && ({1'b0, head_time} > cycle_plus1)) begin
            cycle_d = head_time;
        end else if (cycle_q != '1) begin
            cycle_d = cycle_plus1[TIME_WIDTH-1:0];
        end else begin
            cycle_d = cycle_q;
        end

        last_time_d = push ? in_time : last_time_q;
        order_err_d = order_err_q | (push && (in_time < last_time_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cycle_q     <= '0;
            last_time_q <= '0;
            order_err_q <= 1'b0;
            started_q   <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            cycle_q     <= cycle_d;
            last_time_q <= last_time_d;
            order_err_q <= order_err_d;
            started_q   <= 1'b1;
        end
    end

    // Storage needs no reset: validity is tracked entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            time_mem[wr_ptr_q] <= in_time;
            op_mem[wr_ptr_q]   <= in_op;
            addr_mem[wr_ptr_q] <= in_address;
        end
    end

    assign out_op      = op_mem[rd_ptr_q];
    assign out_address = addr_mem[rd_ptr_q];
    assign out_time    = head_time;
    assign cycle_count = cycle_q;
    assign occupancy   = count_q;
    assign order_err   = order_err_q;

endmodule

`default_nettype wire

// File: tb/tb_trace_scheduler.sv
`default_nettype none
// ============================================================================
// tb_trace_scheduler : directed bench for trace_scheduler (counting and
//                      idle-skip instances driven from the same stimulus).
// Revision           : 1.0
// ============================================================================

module tb_trace_scheduler;
    import global_defs::*;

    localparam int AW    = 33;
    localparam int TW    = 32;
    localparam int DEPTH = 8;
    localparam int OW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [TW-1:0] in_time = '0;
    parsed_op_t    in_op = OP_NOP;
    logic [AW-1:0] in_address = '0;
    logic          out_ready = 1'b0;

    logic          in_ready, out_valid, order_err;
    parsed_op_t    out_op;
    logic [AW-1:0] out_address;
    logic [TW-1:0] out_time, cycle_count;
    logic [OW-1:0] occupancy;

    logic          s_in_ready, s_out_valid, s_order_err;
    parsed_op_t    s_out_op;
    logic [AW-1:0] s_out_address;
    logic [TW-1:0] s_out_time, s_cycle_count;
    logic [OW-1:0] s_occupancy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trace_scheduler #(.ADDRESS_WIDTH(AW), .TIME_WIDTH(TW), .DEPTH(DEPTH), .SKIP_IDLE(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_time(in_time), .in_op(in_op),
        .in_address(in_address),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .out_address(out_address), .out_time(out_time),
        .cycle_count(cycle_count), .occupancy(occupancy), .order_err(order_err)
    );

    trace_scheduler #(.ADDRESS_WIDTH(AW), .TIME_WIDTH(TW), .DEPTH(DEPTH), .SKIP_IDLE(1)) dut_skip (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_time(in_time), .in_op(in_op),
        .in_address(in_address),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_op(s_out_op),
        .out_address(s_out_address), .out_time(s_out_time),
        .cycle_count(s_cycle_count), .occupancy(s_occupancy), .order_err(s_order_err)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [TW-1:0] t, input parsed_op_t op, input logic [AW-1:0] a);
        int n = 0;
        in_valid   = 1'b1;
        in_time    = t;
        in_op      = op;
        in_address = a;
        while (in_ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        cyc();
        in_valid = 1'b0;
    endtask

    // Leaves the bench one cycle after release: cycle_count == 1.
    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        vectors++; if (cycle_count !== '0) begin miscompares++; $display("FAIL reset_cycle: got %0d expected 0", cycle_count); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        vectors++; if (occupancy !== '0) begin miscompares++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
        vectors++; if (order_err !== 1'b0) begin miscompares++; $display("FAIL reset_order_err: got %b expected 0", order_err); end
        rst_n = 1'b1;
        cyc();
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
        vectors++; if (cycle_count !== 32'd1) begin miscompares++; $display("FAIL release_cycle: got %0d expected 1", cycle_count); end
    endtask

    task automatic test_same_time();
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        push(32'd5, OP_READ, 33'h1A0);
        push(32'd5, OP_WRITE, 33'h2B0);
        while (out_valid !== 1'b1 && n < 50) begin cyc(); n++; end
        vectors++; if (cycle_count !== 32'd5) begin miscompares++; $display("FAIL same_time_cycle0: got %0d expected 5", cycle_count); end
        vectors++; if (out_op !== OP_READ || out_address !== 33'h1A0) begin miscompares++; $display("FAIL same_time_req0: got op %0d addr %0h expected op 1 addr 1a0", out_op, out_address); end
        vectors++; if (out_time !== 32'd5) begin miscompares++; $display("FAIL same_time_time0: got %0d expected 5", out_time); end
        cyc();
        vectors++; if (out_valid !== 1'b1 || cycle_count !== 32'd6) begin miscompares++; $display("FAIL same_time_issue1: got valid %b cycle %0d expected valid 1 cycle 6", out_valid, cycle_count); end
        vectors++; if (out_op !== OP_WRITE || out_address !== 33'h2B0 || out_time !== 32'd5) begin miscompares++; $display("FAIL same_time_req1: got op %0d addr %0h time %0d expected op 2 addr 2b0 time 5", out_op, out_address, out_time); end
        cyc();
        vectors++; if (out_valid !== 1'b0 || occupancy !== '0) begin miscompares++; $display("FAIL same_time_drain: got valid %b occ %0d expected valid 0 occ 0", out_valid, occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_full();
        int n = 0;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(32'd100, OP_READ, AW'(i));
        vectors++; if (occupancy !== OW'(DEPTH)) begin miscompares++; $display("FAIL full_occupancy: got %0d expected %0d", occupancy, DEPTH); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        in_valid   = 1'b1;
        in_time    = 32'd100;
        in_op      = OP_WRITE;
        in_address = 33'h999;
        while (out_valid !== 1'b1 && n < 200) begin cyc(); n++; end
        vectors++; if (out_valid !== 1'b1 || occupancy !== OW'(DEPTH)) begin miscompares++; $display("FAIL full_ignore: got valid %b occ %0d expected valid 1 occ %0d", out_valid, occupancy, DEPTH); end
        out_ready = 1'b1;
        cyc();
        vectors++; if (occupancy !== OW'(DEPTH - 1)) begin miscompares++; $display("FAIL full_pop_no_push: got %0d expected %0d", occupancy, DEPTH - 1); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL full_ready_rise: got %b expected 1", in_ready); end
        cyc();
        in_valid = 1'b0;
        vectors++; if (occupancy !== OW'(DEPTH - 1) || out_address !== 33'h2) begin miscompares++; $display("FAIL full_push_pop: got occ %0d head %0h expected occ %0d head 2", occupancy, out_address, DEPTH - 1); end
        n = 0;
        while (occupancy !== '0 && n < 50) begin cyc(); n++; end
        vectors++; if (occupancy !== '0) begin miscompares++; $display("FAIL full_drain: got %0d expected 0", occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        do_reset();
        push(32'd10, OP_READ, 33'h3C0);
        while (cycle_count !== 32'd10 && n < 50) begin cyc(); n++; end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (out_valid !== 1'b1 || out_address !== 33'h3C0 || out_time !== 32'd10 ||
                out_op !== OP_READ || cycle_count !== TW'(10 + k)) begin
                miscompares++;
                $display("FAIL hold_stable: got valid %b addr %0h time %0d cycle %0d expected valid 1 addr 3c0 time 10 cycle %0d",
                         out_valid, out_address, out_time, cycle_count, 10 + k);
            end
            cyc();
        end
        out_ready = 1'b1;
        vectors++; if (out_valid !== 1'b1 || cycle_count !== 32'd14) begin miscompares++; $display("FAIL hold_issue: got valid %b cycle %0d expected valid 1 cycle 14", out_valid, cycle_count); end
        cyc();
        vectors++; if (out_valid !== 1'b0 || occupancy !== '0) begin miscompares++; $display("FAIL hold_drain: got valid %b occ %0d expected valid 0 occ 0", out_valid, occupancy); end
        out_ready = 1'b0;
    endtask

    task automatic test_skip_idle();
        int n = 0;
        do_reset();
        cyc();
        out_ready = 1'b1;
        push(32'd1000, OP_READ, 33'h4D0);
        vectors++; if (s_cycle_count !== 32'd3 || s_occupancy !== OW'(1)) begin miscompares++; $display("FAIL skip_pushed: got cycle %0d occ %0d expected cycle 3 occ 1", s_cycle_count, s_occupancy); end
        cyc();
        vectors++; if (s_cycle_count !== 32'd1000) begin miscompares++; $display("FAIL skip_jump: got %0d expected 1000", s_cycle_count); end
        vectors++; if (s_out_valid !== 1'b1 || s_out_time !== 32'd1000 || s_out_address !== 33'h4D0) begin miscompares++; $display("FAIL skip_issue: got valid %b time %0d addr %0h expected valid 1 time 1000 addr 4d0", s_out_valid, s_out_time, s_out_address); end
        vectors++; if (cycle_count !== 32'd4) begin miscompares++; $display("FAIL noskip_count: got %0d expected 4", cycle_count); end
        cyc();
        vectors++; if (s_occupancy !== '0) begin miscompares++; $display("FAIL skip_drain: got %0d expected 0", s_occupancy); end
        while (out_valid !== 1'b1 && n < 1100) begin cyc(); n++; end
        vectors++; if (out_valid !== 1'b1 || cycle_count !== 32'd1000 || out_address !== 33'h4D0) begin miscompares++; $display("FAIL noskip_issue: got valid %b cycle %0d addr %0h expected valid 1 cycle 1000 addr 4d0", out_valid, cycle_count, out_address); end
        cyc();
        out_ready = 1'b0;
    endtask

    task automatic test_order_nop();
        int n = 0;
        do_reset();
        out_ready = 1'b1;
        push(32'd20, OP_READ, 33'h100);
        push(32'd15, OP_WRITE, 33'h200);
        vectors++; if (order_err !== 1'b1) begin miscompares++; $display("FAIL order_err_set: got %b expected 1", order_err); end
        while (out_valid !== 1'b1 && n < 50) begin cyc(); n++; end
        vectors++; if (cycle_count !== 32'd20 || out_op !== OP_READ || out_time !== 32'd20) begin miscompares++; $display("FAIL order_first: got cycle %0d op %0d time %0d expected cycle 20 op 1 time 20", cycle_count, out_op, out_time); end
        cyc();
        vectors++; if (out_valid !== 1'b1 || out_op !== OP_WRITE || out_time !== 32'd15 || cycle_count !== 32'd21) begin miscompares++; $display("FAIL order_late: got valid %b op %0d time %0d cycle %0d expected valid 1 op 2 time 15 cycle 21", out_valid, out_op, out_time, cycle_count); end
        cyc();
        in_valid   = 1'b1;
        in_time    = 32'd7;
        in_op      = OP_NOP;
        in_address = 33'h0;
        cyc();
        vectors++; if (out_valid !== 1'b0 || occupancy !== OW'(1)) begin miscompares++; $display("FAIL nop_silent: got valid %b occ %0d expected valid 0 occ 1", out_valid, occupancy); end
        in_time    = 32'd8;
        in_op      = OP_READ;
        in_address = 33'h300;
        cyc();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_address !== 33'h300 || occupancy !== OW'(1)) begin miscompares++; $display("FAIL nop_then_read: got valid %b addr %0h occ %0d expected valid 1 addr 300 occ 1", out_valid, out_address, occupancy); end
        cyc();
        vectors++; if (occupancy !== '0 || order_err !== 1'b1) begin miscompares++; $display("FAIL order_sticky: got occ %0d err %b expected occ 0 err 1", occupancy, order_err); end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int issued = 0;
        do_reset();
        push(32'd500, OP_READ, 33'h1);
        push(32'd400, OP_READ, 33'h2);
        push(32'd600, OP_WRITE, 33'h3);
        vectors++; if (occupancy !== OW'(3) || order_err !== 1'b1) begin miscompares++; $display("FAIL mid_loaded: got occ %0d err %b expected occ 3 err 1", occupancy, order_err); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (occupancy !== '0 || cycle_count !== '0) begin miscompares++; $display("FAIL mid_async_state: got occ %0d cycle %0d expected 0 0", occupancy, cycle_count); end
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || order_err !== 1'b0) begin miscompares++; $display("FAIL mid_async_flags: got valid %b ready %b err %b expected 0 0 0", out_valid, in_ready, order_err); end
        cyc();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 700; k++) begin
            if (out_valid === 1'b1) issued++;
            cyc();
        end
        vectors++; if (issued !== 0 || occupancy !== '0) begin miscompares++; $display("FAIL mid_no_issue: got issued %0d occ %0d expected 0 0", issued, occupancy); end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_same_time();
        test_full();
        test_backpressure();
        test_skip_idle();
        test_order_nop();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/trace_scheduler.md
TRACE_SCHEDULER -- requirements
Module: trace_scheduler

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 33, request address width.
REQ-002 Parameter TIME_WIDTH, default 32, timestamp and cycle-counter width.
REQ-003 Parameter DEPTH, default 8, buffer entries; power of two, >= 2.
REQ-004 Parameter SKIP_IDLE, default 0, 1 enables idle time-skip.
REQ-005 clk  in  1  single clock; all state updates on posedge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 in_valid  in  1  trace entry offered.
REQ-008 in_ready  out  1  entry accepted when in_valid && in_ready.
REQ-009 in_time  in  TIME_WIDTH  entry's scheduled cycle.
REQ-010 in_op  in  parsed_op_t  entry opcode (global_defs); NOP legal.
REQ-011 in_address  in  ADDRESS_WIDTH  entry address.
REQ-012 out_valid  out  1  request presented downstream.
REQ-013 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-014 out_op  out  parsed_op_t  issued opcode.
REQ-015 out_address  out  ADDRESS_WIDTH  issued address.
REQ-016 out_time  out  TIME_WIDTH  issued entry's in_time value.
REQ-017 cycle_count  out  TIME_WIDTH  current simulated cycle.
REQ-018 occupancy  out  $clog2(DEPTH)+1  entries buffered.
REQ-019 order_err  out  1  sticky: timestamp went backwards.

Function
REQ-020 Buffer SHALL be an in-order FIFO of DEPTH entries {time, op, address}; in_ready = (occupancy < DEPTH); no full-cycle bypass.
REQ-021 Push and pop in the same cycle SHALL leave occupancy unchanged; an entry pushed into an empty buffer is at head the next cycle (minimum 1-cycle latency).
REQ-022 Head is "due" when buffer non-empty and head.time <= cycle_count (unsigned).
REQ-023 out_valid SHALL equal (head due && head.op != NOP); out_op/out_address/out_time driven from head.
REQ-024 Pop on out_valid && out_ready; at most one issue per cycle.
REQ-025 Due NOP head SHALL be popped silently in one cycle, out_valid low that cycle.
REQ-026 While out_valid && !out_ready, head and outputs SHALL hold stable; cycle_count keeps advancing.
REQ-027 Late entries (time < cycle_count) SHALL issue as soon as at head; never dropped.
REQ-028 cycle_count SHALL increment by 1 per clock, saturating at all-ones.
REQ-029 SKIP_IDLE=1: if buffer non-empty, head.time > cycle_count + 1, and no push this cycle, cycle_count SHALL load head.time next cycle instead of incrementing.
REQ-030 SKIP_IDLE=0: cycle_count never jumps.
REQ-031 order_err SHALL set on any accepted entry whose in_time < previous accepted in_time; entry still accepted; cleared only by reset.
REQ-032 in_valid without in_ready SHALL be ignored; upstream holds payload.
REQ-033 out_* payload while out_valid low is don't-care.

Reset
REQ-034 rst_n low SHALL asynchronously clear buffer, occupancy=0, cycle_count=0, order_err=0, out_valid=0, in_ready=0, last-accepted time=0.
REQ-035 First posedge after rst_n rises: in_ready=1; cycle_count begins counting.
REQ-036 Reset mid-operation SHALL discard buffered entries; no issue until new pushes.

Verification
REQ-037 Push {t=5,READ,0x1A0}, {t=5,WRITE,0x2B0}, out_ready=1 -> READ issues at cycle_count=5, WRITE at 6, out_time=5 both.
REQ-038 Push DEPTH entries t=100, SKIP_IDLE=0 -> in_ready low at full; simultaneous pop+offered push not accepted; in_ready rises after pop.
REQ-039 Head due at 10, out_ready low cycles 10-13 -> out_valid high, payload stable, cycle_count reaches 14 at issue.
REQ-040 SKIP_IDLE=1, single entry t=1000 pushed at cycle 3 -> cycle_count jumps to 1000, issues at 1000; SKIP_IDLE=0 -> issues at 1000 after counting.
REQ-041 Push t=20 then t=15 -> order_err=1; both issue in push order; {t=7,NOP} before {t=8,READ} -> only READ issues.
REQ-042 Assert rst_n low with 3 entries buffered -> all outputs at reset values immediately; no issue after release without new pushes.
